// File: rtl/fetch_pc_ctrl_if.sv
// Fetch PC controller bus: BPT prediction, ID resolution and fetch status signals.
// br_cnt/mispred_cnt exist only when FETCH_PC_STATS_EN is defined.
interface fetch_pc_ctrl_if #(
  parameter int CNT_W = 2
);
  logic              stall;
  logic              bpt_taken;
  logic [63:0]       bpt_target;
  logic              id_pop;
  logic              res_valid;
  logic              res_taken;
  logic [63:0]       res_target;
  logic [63:0]       IF_PC;
  logic              fetch_valid;
  logic              flush;
  logic [CNT_W-1:0]  inflight_cnt;
  logic              err_underflow;
`ifdef FETCH_PC_STATS_EN
  logic [31:0]       br_cnt;
  logic [31:0]       mispred_cnt;
`endif

  modport master (
    output stall, bpt_taken, bpt_target, id_pop, res_valid, res_taken, res_target,
    input  IF_PC, fetch_valid, flush, inflight_cnt, err_underflow
`ifdef FETCH_PC_STATS_EN
    , input br_cnt, mispred_cnt
`endif
  );

  modport slave (
    input  stall, bpt_taken, bpt_target, id_pop, res_valid, res_taken, res_target,
    output IF_PC, fetch_valid, flush, inflight_cnt, err_underflow
`ifdef FETCH_PC_STATS_EN
    , output br_cnt, mispred_cnt
`endif
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC sequencer: issues BPT-steered PCs, tracks predictions in flight, redirects on mispredict.
// Optional branch/mispredict statistics counters enabled by FETCH_PC_STATS_EN.
module fetch_pc_ctrl #(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_ctrl_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {BOOT, RUN, RECOVER} state_t;

  state_t             state, state_nxt;
  logic [63:0]        pc;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               err_q;
  logic               flush_c;

  logic [63:0]        q_pc  [DEPTH];
  logic               q_tkn [DEPTH];
  logic [63:0]        q_tgt [DEPTH];

  logic               pop_act, pop_ok, underflow, mispredict, push;
  logic [63:0]        head_seq, pred_next, act_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // RECOVER ignores id_pop entirely; the queue is already empty there.
  assign pop_act    = bus.id_pop && (state != RECOVER);
  assign pop_ok     = pop_act && (cnt != '0);
  assign underflow  = pop_act && (cnt == '0);
  assign head_seq   = q_pc[rd_ptr] + 64'd4;
  assign pred_next  = q_tkn[rd_ptr] ? q_tgt[rd_ptr] : head_seq;
  assign act_next   = bus.res_taken ? bus.res_target : head_seq;
  assign mispredict = pop_ok && bus.res_valid && (pred_next != act_next);
  assign push       = (state == RUN) && !bus.stall && ((cnt < CNT_W'(DEPTH)) || pop_ok) && !mispredict;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    flush_c   = 1'b0;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (mispredict) state_nxt = RECOVER;
      RECOVER: begin
        flush_c   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // control state: PC, occupancy, pointers, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (underflow) err_q <= 1'b1;
      if (mispredict) begin
        pc     <= act_next;
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc     <= bus.bpt_taken ? bus.bpt_target : pc + 64'd4;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop_ok)      cnt <= cnt + 1'b1;
        else if (!push && pop_ok) cnt <= cnt - 1'b1;
      end
    end
  end

  // in-flight payload, written on issue only
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]  <= pc;
      q_tkn[wr_ptr] <= bus.bpt_taken;
      q_tgt[wr_ptr] <= bus.bpt_target;
    end
  end

`ifdef FETCH_PC_STATS_EN
  logic [31:0] br_q, mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (pop_ok && bus.res_valid) br_q <= sat_inc(br_q);
      if (mispredict)              mp_q <= sat_inc(mp_q);
    end
  end

  assign bus.br_cnt      = br_q;
  assign bus.mispred_cnt = mp_q;
`endif

  assign bus.IF_PC         = pc;
  assign bus.fetch_valid   = push;
  assign bus.flush         = flush_c;
  assign bus.inflight_cnt  = cnt;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomized scoreboard bench for fetch_pc_ctrl against a queue-based reference model.
module tb_fetch_pc_ctrl;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int NCYC   = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.CNT_W(CNT_W)) bus();

  fetch_pc_ctrl #(.DEPTH(DEPTH), .RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic        taken;
    logic [63:0] tgt;
  } ent_t;

  typedef struct {
    logic        fv;
    logic [63:0] pc;
    logic        fl;
    int          cnt;
    logic        err;
    int unsigned br;
    int unsigned mp;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];

  logic [63:0] m_pc;
  bit          m_boot, m_rec, m_err;
  int unsigned m_br, m_mp;
  int          vectors = 0;
  int          miscompares = 0;

  int pop_tab[8]   = '{70, 0, 40, 100, 20, 90, 50, 10};
  int stall_tab[8] = '{0, 10, 30, 0, 60, 5, 20, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 64'h0;
    m_boot = 1'b1;
    m_rec  = 1'b0;
    m_err  = 1'b0;
    m_br   = 0;
    m_mp   = 0;
    mq.delete();
  endtask

  function automatic logic [63:0] rand_target();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)     return 64'hFFFF_FFFF_FFFF_FFFC;
    else if (sel < 6) return 64'($urandom_range(0, 255)) << 2;
    else              return {$urandom, $urandom} & ~64'h3;
  endfunction

  // monitor: compare every observed cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("fetch_valid",   64'(bus.fetch_valid),   64'(e.fv));
        check("IF_PC",         bus.IF_PC,              e.pc);
        check("flush",         64'(bus.flush),         64'(e.fl));
        check("inflight_cnt",  64'(bus.inflight_cnt),  64'(e.cnt));
        check("err_underflow", 64'(bus.err_underflow), 64'(e.err));
`ifdef FETCH_PC_STATS_EN
        check("br_cnt",        64'(bus.br_cnt),        64'(e.br));
        check("mispred_cnt",   64'(bus.mispred_cnt),   64'(e.mp));
`endif
      end
    end
  end

  // driver + reference model
  initial begin
    exp_t        e;
    logic        pop_act, pop_ok, und, mis, fv;
    logic [63:0] pred, act;
    int          blk;

    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.bpt_taken  = 1'b0;
    bus.bpt_target = '0;
    bus.id_pop     = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_taken  = 1'b0;
    bus.res_target = '0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      blk = (cyc / 64) % 8;
      if (cyc < 6) begin
        rst           = 1'b0;
        bus.stall     = 1'b0;
        bus.bpt_taken = 1'b0;
        bus.id_pop    = 1'b0;
      end else begin
        rst           = (m_rec && $urandom_range(0, 99) < 25) || ($urandom_range(0, 999) < 5);
        bus.stall     = $urandom_range(0, 99) < stall_tab[blk];
        bus.bpt_taken = $urandom_range(0, 99) < 40;
        bus.id_pop    = $urandom_range(0, 99) < pop_tab[blk];
      end
      bus.bpt_target = rand_target();
      bus.res_valid  = $urandom_range(0, 99) < 70;
      if (mq.size() > 0 && $urandom_range(0, 99) < 65) begin
        bus.res_taken  = mq[0].taken;
        bus.res_target = mq[0].tgt;
      end else begin
        bus.res_taken  = $urandom_range(0, 1);
        bus.res_target = ($urandom_range(0, 1) == 1 || mq.size() == 0) ? rand_target() : mq[0].pc + 64'd4;
      end

      pop_act = bus.id_pop && !m_rec;
      pop_ok  = pop_act && (mq.size() > 0);
      und     = pop_act && (mq.size() == 0);
      mis     = 1'b0;
      act     = '0;
      if (pop_ok && bus.res_valid) begin
        pred = mq[0].taken ? mq[0].tgt : mq[0].pc + 64'd4;
        act  = bus.res_taken ? bus.res_target : mq[0].pc + 64'd4;
        mis  = (pred != act);
      end
      fv = !m_boot && !m_rec && !bus.stall && ((mq.size() < DEPTH) || pop_ok) && !mis;

      e.fv  = fv;
      e.pc  = m_pc;
      e.fl  = m_rec;
      e.cnt = mq.size();
      e.err = m_err;
      e.br  = m_br;
      e.mp  = m_mp;
      sb.push_back(e);

      if (rst) begin
        model_reset();
      end else begin
        if (und) m_err = 1'b1;
        if (pop_ok && bus.res_valid) m_br++;
        m_boot = 1'b0;
        if (mis) begin
          m_mp++;
          m_pc  = act;
          mq.delete();
          m_rec = 1'b1;
        end else begin
          m_rec = 1'b0;
          if (pop_ok) void'(mq.pop_front());
          if (fv) begin
            mq.push_back('{m_pc, bus.bpt_taken, bus.bpt_target});
            m_pc = bus.bpt_taken ? bus.bpt_target : m_pc + 64'd4;
          end
        end
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
